// File: rtl/crc_bit_stuffer.sv
// crc_bit_stuffer: USB TX serializer. Loads a token or DATA0 packet, sends it
//   LSB first with its complemented CRC5/CRC16 field, and applies bit stuffing.
// Latency: load accepted at edge N -> PID bit 0 on bs_out_bit after edge N+1.
// Backpressure: none upstream (strobes are dropped while busy); the stuffer
//   stalls the active CRC unit for one cycle per stuffed zero.
// Ports: clock, reset_n (async, active low); crc5_pkt_in/crc5_pkt_ready (token),
//   crc16_pkt_in/crc16_pkt_ready (data); bs_out_bit/bs_sending (serial out).

// crc_serializer: shifts out PID, then the CRC-covered body, then the field.
// Latency: out_bit_o is combinational from registered state; valid the cycle after load_i.
// Backpressure: holds the current bit while bs_ready_i is low.
module crc_serializer #(
  parameter int               BODY_W = 11,
  parameter int               CRC_W  = 5,
  parameter logic [CRC_W-1:0] POLY   = 5'h05
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic [BODY_W+7:0] pkt_i,
  input  logic              bs_ready_i,
  output logic              crc_valid_out_o,
  output logic              out_bit_o
);

  localparam int PKT_W = BODY_W + 8;
  localparam int CNT_W = $clog2(PKT_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PID,
    S_BODY,
    S_CRC
  } state_e;

  state_e             state_q, state_d;
  logic [PKT_W-1:0]   sr_q, sr_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fb;

  always_comb begin
    state_d         = state_q;
    sr_d            = sr_q;
    crc_d           = crc_q;
    cnt_d           = cnt_q;
    crc_valid_out_o = 1'b0;
    out_bit_o       = 1'b0;
    fb              = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          state_d = S_PID;
          sr_d    = pkt_i;
          crc_d   = '1;
          cnt_d   = '0;
        end
      end
      S_PID: begin
        crc_valid_out_o = 1'b1;
        out_bit_o       = sr_q[0];
        if (bs_ready_i) begin
          sr_d = sr_q >> 1;
          if (cnt_q == CNT_W'(7)) begin
            cnt_d   = '0;
            state_d = S_BODY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_BODY: begin
        crc_valid_out_o = 1'b1;
        out_bit_o       = sr_q[0];
        // CRC advances only when the bit is actually taken, so a stuff
        // stall cannot fold the same bit in twice.
        if (bs_ready_i) begin
          sr_d  = sr_q >> 1;
          fb    = sr_q[0] ^ crc_q[CRC_W-1];
          crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
          if (cnt_q == CNT_W'(BODY_W - 1)) begin
            cnt_d   = '0;
            state_d = S_CRC;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CRC: begin
        // Field goes out as the complemented remainder, high-order term first.
        crc_valid_out_o = 1'b1;
        out_bit_o       = ~crc_q[CRC_W-1];
        if (bs_ready_i) begin
          crc_d = {crc_q[CRC_W-2:0], 1'b0};
          if (cnt_q == CNT_W'(CRC_W - 1)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      crc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// bit_stuffer: registers one bit per cycle, inserting a 0 after six 1s.
// Latency: one cycle from crc_valid_out_i/out_bit_i to bs_out_bit_o.
// Backpressure: drops bs_ready_o for the cycle that carries a stuffed zero.
module bit_stuffer (
  input  logic clock,
  input  logic reset_n,
  input  logic start_i,
  input  logic crc_valid_out_i,
  input  logic out_bit_i,
  output logic bs_ready_o,
  output logic bs_out_bit_o,
  output logic bs_sending_o
);

  logic [2:0] ones_q, ones_d;
  logic       out_q, out_d;
  logic       sending_q, sending_d;
  logic       stuff;

  // Six emitted 1s in a row: the next cycle must be a stuffed zero. This
  // also covers a run completed by the final CRC bit.
  assign stuff      = (ones_q == 3'd6);
  assign bs_ready_o = ~stuff;

  always_comb begin
    ones_d    = ones_q;
    out_d     = 1'b0;
    sending_d = 1'b0;
    if (start_i) begin
      ones_d = '0;
    end else if (stuff) begin
      sending_d = 1'b1;
      ones_d    = '0;
    end else if (crc_valid_out_i) begin
      out_d     = out_bit_i;
      sending_d = 1'b1;
      ones_d    = out_bit_i ? (ones_q + 3'd1) : 3'd0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ones_q    <= '0;
      out_q     <= 1'b0;
      sending_q <= 1'b0;
    end else begin
      ones_q    <= ones_d;
      out_q     <= out_d;
      sending_q <= sending_d;
    end
  end

  assign bs_out_bit_o = out_q;
  assign bs_sending_o = sending_q;

endmodule

module crc_bit_stuffer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [18:0] crc5_pkt_in,
  input  logic        crc5_pkt_ready,
  input  logic [71:0] crc16_pkt_in,
  input  logic        crc16_pkt_ready,
  output logic        bs_out_bit,
  output logic        bs_sending
);

  logic crc5_valid_out, crc5_out_bit;
  logic crc16_valid_out, crc16_out_bit;
  logic bs_ready;
  logic idle;
  logic load5, load16;
  logic mux_valid, mux_bit;

  // Idle means nothing on the wire and nothing queued in either unit; the
  // cycle right after a load is therefore not idle.
  assign idle   = ~bs_sending & ~crc5_valid_out & ~crc16_valid_out;
  assign load5  = crc5_pkt_ready & idle;
  assign load16 = crc16_pkt_ready & ~crc5_pkt_ready & idle;

  crc_serializer #(
    .BODY_W (11),
    .CRC_W  (5),
    .POLY   (5'h05)
  ) u_crc5 (
    .clock           (clock),
    .reset_n         (reset_n),
    .load_i          (load5),
    .pkt_i           (crc5_pkt_in),
    .bs_ready_i      (bs_ready),
    .crc_valid_out_o (crc5_valid_out),
    .out_bit_o       (crc5_out_bit)
  );

  crc_serializer #(
    .BODY_W (64),
    .CRC_W  (16),
    .POLY   (16'h8005)
  ) u_crc16 (
    .clock           (clock),
    .reset_n         (reset_n),
    .load_i          (load16),
    .pkt_i           (crc16_pkt_in),
    .bs_ready_i      (bs_ready),
    .crc_valid_out_o (crc16_valid_out),
    .out_bit_o       (crc16_out_bit)
  );

  // At most one unit is active, so a simple priority mux is enough.
  assign mux_valid = crc5_valid_out | crc16_valid_out;
  assign mux_bit   = crc5_valid_out ? crc5_out_bit : crc16_out_bit;

  bit_stuffer u_stuffer (
    .clock           (clock),
    .reset_n         (reset_n),
    .start_i         (load5 | load16),
    .crc_valid_out_i (mux_valid),
    .out_bit_i       (mux_bit),
    .bs_ready_o      (bs_ready),
    .bs_out_bit_o    (bs_out_bit),
    .bs_sending_o    (bs_sending)
  );

endmodule

// File: tb/tb_crc_bit_stuffer.sv
module tb_crc_bit_stuffer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [18:0] crc5_pkt_in;
  logic        crc5_pkt_ready;
  logic [71:0] crc16_pkt_in;
  logic        crc16_pkt_ready;
  logic        bs_out_bit;
  logic        bs_sending;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];
  int exp_len_q[$];
  int run_len = 0;
  bit obs[256];
  int obs_n = 0;

  crc_bit_stuffer dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .crc5_pkt_in     (crc5_pkt_in),
    .crc5_pkt_ready  (crc5_pkt_ready),
    .crc16_pkt_in    (crc16_pkt_in),
    .crc16_pkt_ready (crc16_pkt_ready),
    .bs_out_bit      (bs_out_bit),
    .bs_sending      (bs_sending)
  );

  always #5 clock = ~clock;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [71:0] rand72(input bit dense);
    logic [71:0] v;
    v[31:0]  = $urandom();
    v[63:32] = $urandom();
    v[71:64] = 8'($urandom());
    if (dense) begin
      v[31:0]  = v[31:0] | $urandom();
      v[63:32] = v[63:32] | $urandom() | $urandom();
    end
    return v;
  endfunction

  task automatic scramble();
    crc5_pkt_in  = 19'($urandom());
    crc16_pkt_in = rand72(1'b0);
  endtask

  // Reference: reflected (LSB-first) CRC, complemented and sent LSB first,
  // then a plain walk over the bit list inserting a 0 after every six 1s.
  task automatic push_expected(input bit tok, input logic [71:0] pkt, output int len);
    bit          u[$];
    int unsigned c, mask, rpoly;
    int          nb, nc, ones, ns;
    for (int i = 0; i < 8; i++) u.push_back(pkt[i]);
    nb    = tok ? 11 : 64;
    nc    = tok ? 5 : 16;
    mask  = tok ? 32'h1F : 32'hFFFF;
    rpoly = tok ? 32'h14 : 32'hA001;
    c     = mask;
    for (int i = 0; i < nb; i++) begin
      u.push_back(pkt[8+i]);
      if ((c[0] ^ pkt[8+i]) == 1'b1) c = (c >> 1) ^ rpoly;
      else                           c = c >> 1;
    end
    c = ~c & mask;
    for (int i = 0; i < nc; i++) u.push_back(c[i]);
    ones = 0;
    ns   = 0;
    foreach (u[i]) begin
      exp_q.push_back(u[i]);
      if (u[i]) ones++;
      else      ones = 0;
      if (ones == 6) begin
        exp_q.push_back(1'b0);
        ones = 0;
        ns++;
      end
    end
    len = u.size() + ns;
    exp_len_q.push_back(len);
  endtask

  // Called at a negedge in an idle cycle; returns at the negedge of the first
  // idle cycle after the packet.
  task automatic send(input bit tok, input logic [18:0] p5, input logic [71:0] p16,
                      input bit both, input bit poke_mid, input bit poke_last);
    int len;
    crc5_pkt_in     = p5;
    crc16_pkt_in    = p16;
    crc5_pkt_ready  = tok;
    crc16_pkt_ready = !tok || both;
    if (tok) push_expected(1'b1, {53'b0, p5}, len);
    else     push_expected(1'b0, p16, len);
    @(negedge clock);
    crc5_pkt_ready  = 1'b0;
    crc16_pkt_ready = 1'b0;
    scramble();
    check_bit("latency_edge_n", bs_sending, 1'b0);
    @(negedge clock);
    check_bit("latency_edge_n1", bs_sending, 1'b1);
    for (int k = 0; k < len; k++) begin
      if ((poke_mid && k == 10) || (poke_last && k == len - 1)) begin
        scramble();
        crc5_pkt_ready  = 1'b1;
        crc16_pkt_ready = 1'b1;
      end
      @(negedge clock);
      crc5_pkt_ready  = 1'b0;
      crc16_pkt_ready = 1'b0;
    end
    check_bit("sending_fall", bs_sending, 1'b0);
  endtask

  // Monitor: pops one expected bit per sending cycle, checks run length at the fall.
  initial begin : monitor
    bit e;
    int l;
    forever begin
      @(negedge clock);
      if (bs_sending === 1'b1) begin
        if (run_len == 0) obs_n = 0;
        run_len++;
        if (obs_n < 256) obs[obs_n] = bs_out_bit;
        obs_n++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_bit: got %0b with no expected bit queued", bs_out_bit);
        end else begin
          e = exp_q.pop_front();
          if (bs_out_bit !== e) begin
            errors++;
            $display("FAIL stream_bit[%0d]: got %0b expected %0b", obs_n - 1, bs_out_bit, e);
          end
        end
      end else if (run_len > 0) begin
        checks++;
        if (exp_len_q.size() == 0) begin
          errors++;
          $display("FAIL run_length: got %0d with no packet expected", run_len);
        end else begin
          l = exp_len_q.pop_front();
          if (run_len != l) begin
            errors++;
            $display("FAIL run_length: got %0d expected %0d", run_len, l);
          end
        end
        run_len = 0;
      end
    end
  end

  initial begin : driver
    int   zeros;
    int   dummy;
    bit   tok;
    reset_n         = 1'b0;
    crc5_pkt_in     = '0;
    crc5_pkt_ready  = 1'b0;
    crc16_pkt_in    = '0;
    crc16_pkt_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_bit("reset_bs_sending", bs_sending, 1'b0);
    check_bit("reset_bs_out_bit", bs_out_bit, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);

    // Token, zero address: field 5'h02 -> bits 19..23 = 0,1,0,0,0
    send(1'b1, {4'h0, 7'h00, 8'h2D}, 72'h0, 1'b0, 1'b0, 1'b0);
    check_int("tok0_len", obs_n, 24);
    check_bit("tok0_crc_b19", obs[19], 1'b0);
    check_bit("tok0_crc_b20", obs[20], 1'b1);
    check_bit("tok0_crc_b21", obs[21], 1'b0);
    check_bit("tok0_crc_b22", obs[22], 1'b0);
    check_bit("tok0_crc_b23", obs[23], 1'b0);

    // OUT token, addr 5, endp 1
    send(1'b1, {4'h1, 7'd5, 8'hE1}, 72'h0, 1'b0, 1'b0, 1'b0);

    // DATA0 with all-zero payload
    send(1'b0, 19'h0, {64'h0, 8'hC3}, 1'b0, 1'b0, 1'b0);

    // All-ones payload: PID C3 ends in two 1s, giving a 66-one run that
    // must carry exactly 11 stuffed zeros (stream positions 6..82).
    send(1'b0, 19'h0, {64'hFFFF_FFFF_FFFF_FFFF, 8'hC3}, 1'b0, 1'b0, 1'b0);
    zeros = 0;
    for (int i = 6; i <= 82; i++) if (obs[i] == 1'b0) zeros++;
    check_int("ones_run_stuffs", zeros, 11);
    check_bit("ones_run_last_is_stuff", obs[82], 1'b0);

    // Both strobes together: token wins; later strobes while busy are ignored.
    send(1'b1, 19'($urandom()), rand72(1'b1), 1'b1, 1'b1, 1'b1);

    // Abort during data bit 30 (stream position 38; no stuffing before it).
    crc16_pkt_in    = {64'h0, 8'hC3};
    crc16_pkt_ready = 1'b1;
    push_expected(1'b0, {64'h0, 8'hC3}, dummy);
    @(negedge clock);
    crc16_pkt_ready = 1'b0;
    @(negedge clock);
    repeat (38) @(negedge clock);
    check_bit("pre_abort_sending", bs_sending, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_bit("abort_bs_sending", bs_sending, 1'b0);
    check_bit("abort_bs_out_bit", bs_out_bit, 1'b0);
    exp_q.delete();
    exp_len_q.delete();
    run_len = 0;
    repeat (3) begin
      @(negedge clock);
      check_bit("in_reset_idle", bs_sending, 1'b0);
    end
    #2 reset_n = 1'b1;
    repeat (6) begin
      @(negedge clock);
      check_bit("post_release_idle", bs_sending, 1'b0);
    end
    send(1'b1, {4'h3, 7'h2A, 8'h69}, 72'h0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic, packets started in the first idle cycle.
    for (int n = 0; n < 40; n++) begin
      tok = 1'($urandom_range(0, 1));
      send(tok, 19'($urandom()), rand72(1'($urandom_range(0, 1))),
           1'($urandom_range(0, 1)) & tok, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clock);
    end

    repeat (10) @(negedge clock);
    check_int("leftover_bits", exp_q.size(), 0);
    check_int("leftover_packets", exp_len_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
